// File: rtl/disp_ctrl.sv
// Binary-to-BCD display controller: double-dabble converter with leading-zero
// blanking and an overflow pattern, updating the display once per request.

module disp_dab_digit (
  input  logic [3:0] d,
  output logic [3:0] q
);
  assign q = (d >= 4'd5) ? d + 4'd3 : d;
endmodule

module disp_ctrl #(
  parameter int BIN_W = 20  // only 20 is supported
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             in_valid,
  input  logic [BIN_W-1:0] in_bin,
  output logic             in_ready,
  output logic [23:0]      dispdata,
  output logic [5:0]       blank,
  output logic             err,
  output logic             done
);
  localparam int NUM_DIGITS = 6;
  localparam int BCD_W      = 4 * NUM_DIGITS;
  localparam int CNT_W      = 5;
  localparam logic [BIN_W-1:0] MAX_DEC  = BIN_W'(999999);
  localparam logic [BCD_W-1:0] OVF_PAT  = 24'hEEEEEE;
  localparam logic [5:0]       BLANK_RST = 6'b111110;

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t                         state;
  logic [BIN_W-1:0]               bin_q;
  logic [BCD_W-1:0]               bcd_q;
  logic [CNT_W-1:0]               cnt;
  logic                           ovf_q;
  logic [NUM_DIGITS-1:0][3:0]     bcd_adj;
  logic [BCD_W-1:0]               bcd_adj_flat;
  logic [BCD_W+BIN_W-1:0]         sh;
  logic [5:0]                     blank_nxt;

  // Per-digit "add 3 if >= 5" correction ahead of each shift.
  for (genvar i = 0; i < NUM_DIGITS; i++) begin : g_dig
    disp_dab_digit u_dig (
      .d (bcd_q[4*i +: 4]),
      .q (bcd_adj[i])
    );
  end

  assign bcd_adj_flat = bcd_adj;
  assign sh           = {bcd_adj_flat, bin_q} << 1;
  assign in_ready     = (state == IDLE) && !clr;

  // Digit i is blanked only when it and every more significant digit are zero.
  always_comb begin
    logic nz;
    nz        = 1'b0;
    blank_nxt = '0;
    for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
      nz           = nz | (bcd_q[4*i +: 4] != 4'd0);
      blank_nxt[i] = !nz;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      bin_q    <= '0;
      bcd_q    <= '0;
      cnt      <= '0;
      ovf_q    <= 1'b0;
      dispdata <= '0;
      blank    <= BLANK_RST;
      err      <= 1'b0;
      done     <= 1'b0;
    end else if (clr) begin
      state    <= IDLE;
      cnt      <= '0;
      ovf_q    <= 1'b0;
      dispdata <= '0;
      blank    <= BLANK_RST;
      err      <= 1'b0;
      done     <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (in_valid) begin
            bin_q <= in_bin;
            bcd_q <= '0;
            cnt   <= '0;
            ovf_q <= (in_bin > MAX_DEC);
            state <= (in_bin > MAX_DEC) ? DONE : SHIFT;
          end
        end
        SHIFT: begin
          bcd_q <= sh[BCD_W+BIN_W-1:BIN_W];
          bin_q <= sh[BIN_W-1:0];
          cnt   <= cnt + 1'b1;
          if (cnt == CNT_W'(BIN_W - 1)) state <= DONE;
        end
        DONE: begin
          if (ovf_q) begin
            dispdata <= OVF_PAT;
            blank    <= '0;
            err      <= 1'b1;
          end else begin
            dispdata <= bcd_q;
            blank    <= blank_nxt;
            err      <= 1'b0;
          end
          done  <= 1'b1;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_disp_ctrl.sv
// Bench for disp_ctrl: decimal-arithmetic reference model compared every cycle,
// directed literal cases, then randomized traffic with clr/rst injection.

module tb_disp_ctrl;
  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        clr = 1'b0;
  logic        in_valid = 1'b0;
  logic [19:0] in_bin = '0;
  logic        in_ready;
  logic [23:0] dispdata;
  logic [5:0]  blank;
  logic        err;
  logic        done;

  int n_cmp = 0;
  int n_bad = 0;
  bit chk_en = 1'b0;

  // model state: cycles left until the display update, pending and shown values
  int          m_busy = 0;
  logic [23:0] m_pd, m_disp = '0;
  logic [5:0]  m_pb, m_blank = 6'b111110;
  logic        m_pe, m_err = 1'b0, m_done = 1'b0;

  disp_ctrl #(.BIN_W(20)) dut (
    .clk(clk), .rst(rst), .clr(clr), .in_valid(in_valid), .in_bin(in_bin),
    .in_ready(in_ready), .dispdata(dispdata), .blank(blank), .err(err), .done(done)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic logic [23:0] to_bcd(input int v);
    logic [23:0] r;
    int t;
    r = '0;
    t = v;
    for (int i = 0; i < 6; i++) begin
      r[4*i +: 4] = 4'(t % 10);
      t = t / 10;
    end
    return r;
  endfunction

  function automatic logic [5:0] blank_of(input int v);
    logic [5:0] b;
    int nd, t;
    nd = 1;
    t  = v / 10;
    while (t > 0) begin
      nd++;
      t = t / 10;
    end
    b = '0;
    for (int i = 1; i < 6; i++) b[i] = (i >= nd);
    return b;
  endfunction

  task automatic model_reset();
    m_busy = 0; m_disp = '0; m_blank = 6'b111110; m_err = 1'b0; m_done = 1'b0;
  endtask

  task automatic model_step();
    m_done = 1'b0;
    if (clr) begin
      m_busy = 0; m_disp = '0; m_blank = 6'b111110; m_err = 1'b0;
    end else if (m_busy > 0) begin
      m_busy--;
      if (m_busy == 0) begin
        m_disp = m_pd; m_blank = m_pb; m_err = m_pe; m_done = 1'b1;
      end
    end else if (in_valid) begin
      if (int'(in_bin) > 999999) begin
        m_pd = 24'hEEEEEE; m_pb = '0; m_pe = 1'b1; m_busy = 1;
      end else begin
        m_pd = to_bcd(int'(in_bin)); m_pb = blank_of(int'(in_bin)); m_pe = 1'b0; m_busy = 21;
      end
    end
  endtask

  // Single compare process: model advances on each edge, DUT checked 1 time unit later.
  always begin
    @(posedge clk);
    if (!rst) model_reset();
    else model_step();
    #1;
    if (chk_en) begin
      check("cyc_in_ready", in_ready, (m_busy == 0) && !clr);
      check("cyc_dispdata", dispdata, m_disp);
      check("cyc_blank", blank, m_blank);
      check("cyc_err", err, m_err);
      check("cyc_done", done, m_done);
    end
  end

  task automatic wait_done(input int maxc, output int k);
    k = -1;
    for (int i = 1; i <= maxc; i++) begin
      @(negedge clk);
      if (done) begin
        k = i;
        return;
      end
    end
  endtask

  task automatic no_done_for(input string nm, input int n);
    int seen;
    seen = 0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (done) seen++;
    end
    check(nm, seen, 0);
  endtask

  // Caller is at a negedge; request is accepted on the following posedge (E0).
  task automatic conv(input string nm, input int v, input int lat_exp,
                      input logic [23:0] d_exp, input logic [5:0] b_exp, input logic e_exp);
    int k;
    in_valid = 1'b1;
    in_bin   = 20'(v);
    @(negedge clk);
    in_valid = 1'b0;
    in_bin   = 20'h5A5A5;
    wait_done(30, k);
    check({nm, "_lat"}, k, lat_exp);
    check({nm, "_data"}, dispdata, d_exp);
    check({nm, "_blank"}, blank, b_exp);
    check({nm, "_err"}, err, e_exp);
    @(negedge clk);
    check({nm, "_done_pulse"}, done, 1'b0);
  endtask

  initial begin
    int k, k2;
    repeat (2) @(negedge clk);
    #1;
    check("rst_data", dispdata, 24'h000000);
    check("rst_blank", blank, 6'b111110);
    check("rst_err", err, 1'b0);
    check("rst_done", done, 1'b0);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("rel_ready", in_ready, 1'b1);
    chk_en = 1'b1;
    @(negedge clk);

    conv("v123456", 123456, 21, 24'h123456, 6'b000000, 1'b0);
    conv("v42", 42, 21, 24'h000042, 6'b111100, 1'b0);
    conv("v0", 0, 21, 24'h000000, 6'b111110, 1'b0);
    conv("v999999", 999999, 21, 24'h999999, 6'b000000, 1'b0);
    conv("v1000000", 1000000, 1, 24'hEEEEEE, 6'b000000, 1'b1);
    conv("v1048575", 1048575, 1, 24'hEEEEEE, 6'b000000, 1'b1);
    conv("v90001", 90001, 21, 24'h090001, 6'b100000, 1'b0);

    // back-to-back with in_valid held: 7 then 8
    in_valid = 1'b1;
    in_bin   = 20'd7;
    @(negedge clk);
    in_bin = 20'd8;
    wait_done(30, k);
    check("hold7_lat", k, 21);
    check("hold7_data", dispdata, 24'h000007);
    wait_done(30, k2);
    in_valid = 1'b0;
    check("hold8_lat", k + k2, 43);
    check("hold8_data", dispdata, 24'h000008);
    @(negedge clk);

    // clr at E10 of 555555
    in_valid = 1'b1;
    in_bin   = 20'd555555;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (9) @(negedge clk);
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    #1;
    check("clr_data", dispdata, 24'h000000);
    check("clr_blank", blank, 6'b111110);
    check("clr_ready", in_ready, 1'b1);
    no_done_for("clr_no_done", 25);

    // clr together with a request: not accepted
    clr      = 1'b1;
    in_valid = 1'b1;
    in_bin   = 20'd31;
    @(negedge clk);
    clr      = 1'b0;
    in_valid = 1'b0;
    no_done_for("clrreq_no_done", 25);
    check("clrreq_data", dispdata, 24'h000000);

    // reset mid-conversion (after a nonzero value is on display)
    conv("v271828", 271828, 21, 24'h271828, 6'b000000, 1'b0);
    in_valid = 1'b1;
    in_bin   = 20'd314159;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (4) @(negedge clk);
    rst = 1'b0;
    #1;
    check("arst_data", dispdata, 24'h000000);
    check("arst_blank", blank, 6'b111110);
    check("arst_err", err, 1'b0);
    check("arst_done", done, 1'b0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("arst_rel_ready", in_ready, 1'b1);
    no_done_for("arst_no_done", 25);
    check("arst_no_restore", dispdata, 24'h000000);

    // randomized traffic
    for (int c = 0; c < 3000; c++) begin
      in_valid = ($urandom_range(0, 99) < 35);
      case ($urandom_range(0, 6))
        0: in_bin = 20'($urandom_range(0, 99));
        1: in_bin = 20'd999999;
        2: in_bin = 20'd1000000;
        3: in_bin = 20'($urandom);
        4: in_bin = 20'($urandom_range(0, 999999));
        5: in_bin = 20'hFFFFF;
        default: in_bin = 20'($urandom_range(0, 9999));
      endcase
      clr = ($urandom_range(0, 99) < 2);
      rst = !($urandom_range(0, 299) == 0);
      @(negedge clk);
    end
    clr = 1'b0;
    rst = 1'b1;
    in_valid = 1'b0;
    repeat (30) @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
